// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and sequencing controller for the five-stage core.
//
// Each cycle this block decides whether the PC, IF/ID and ID/EX registers
// advance, hold or take a bubble. It covers:
//   - load-use stalls;
//   - taken branches (resolved in ID);
//   - jumps resolved in EX;
//   - multi-cycle data-memory waits.
// It also runs a memory watchdog and keeps saturating stall/flush counters.
//
// Parameters:
//   STALL_CYCLES  bubbles inserted per load-use hazard (1..7)
//   MEM_TIMEOUT   MemBusy cycles tolerated before MemErr (1..65535)
//
// Ports:
//   Clk, Rst_n          clock (rising edge), asynchronous active-low reset
//   ID_RegRs/ID_RegRt   source registers of the ID instruction
//   ID_UsesRt           ID instruction reads rt
//   EX_MemRead/EX_RegRt load in EX and its destination register
//   BranchTaken         ID comparator resolved a taken branch
//   EX_Jump             j/jal in EX
//   MemBusy             data memory not ready, freeze the pipeline
//   PCHold, IFIDHold    hold PC / IF/ID
//   IFIDFlush           zero IF/ID
//   IDEXWrite           hold ID/EX
//   FlushEnable         zero ID/EX (bubble)
//   MemErr              sticky watchdog error
//   StallCnt, FlushCnt  saturating performance counters
module hazard_ctrl #(
  parameter int unsigned STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [4:0]  ID_RegRs,
  input  logic [4:0]  ID_RegRt,
  input  logic        ID_UsesRt,
  input  logic        EX_MemRead,
  input  logic [4:0]  EX_RegRt,
  input  logic        BranchTaken,
  input  logic        EX_Jump,
  input  logic        MemBusy,
  output logic        PCHold,
  output logic        IFIDHold,
  output logic        IFIDFlush,
  output logic        IDEXWrite,
  output logic        FlushEnable,
  output logic        MemErr,
  output logic [15:0] StallCnt,
  output logic [15:0] FlushCnt
);

  typedef enum logic [1:0] {StRun, StLuStall, StMemWait} state_e;

  localparam logic [2:0]  LuInit    = 3'(STALL_CYCLES - 1);
  localparam logic [15:0] WdogLimit = 16'(MEM_TIMEOUT);
  localparam logic [15:0] CntMax    = 16'hFFFF;

  state_e      state_q, state_d;
  logic [2:0]  lu_cnt_q, lu_cnt_d;
  logic        ret_lu_q, ret_lu_d;
  logic [15:0] wdog_q, wdog_d;
  logic        mem_err_q, mem_err_d;
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  logic lu;
  logic run_rules, stall_rule;
  logic pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush;

  assign lu = EX_MemRead && (EX_RegRt != 5'd0) &&
              ((EX_RegRt == ID_RegRs) || (ID_UsesRt && (EX_RegRt == ID_RegRt)));

  always_comb begin
    state_d    = state_q;
    lu_cnt_d   = lu_cnt_q;
    ret_lu_d   = ret_lu_q;
    wdog_d     = wdog_q;
    run_rules  = 1'b0;
    stall_rule = 1'b0;
    pc_hold    = 1'b0;
    ifid_hold  = 1'b0;
    ifid_flush = 1'b0;
    idex_hold  = 1'b0;
    idex_flush = 1'b0;

    unique case (state_q)
      StRun: begin
        if (MemBusy) begin
          {pc_hold, ifid_hold, idex_hold} = 3'b111;
          state_d  = StMemWait;
          ret_lu_d = 1'b0;
          wdog_d   = 16'd1;
        end else begin
          run_rules = 1'b1;
        end
      end
      StLuStall: begin
        if (MemBusy) begin
          // lu_cnt stays put so the stall resumes where it left off
          {pc_hold, ifid_hold, idex_hold} = 3'b111;
          state_d  = StMemWait;
          ret_lu_d = 1'b1;
          wdog_d   = 16'd1;
        end else begin
          stall_rule = 1'b1;
        end
      end
      StMemWait: begin
        if (MemBusy) begin
          {pc_hold, ifid_hold, idex_hold} = 3'b111;
          wdog_d = (wdog_q == CntMax) ? wdog_q : wdog_q + 16'd1;
        end else if (ret_lu_q) begin
          stall_rule = 1'b1;
        end else begin
          run_rules = 1'b1;
        end
      end
      default: state_d = StRun;
    endcase

    // Jump beats branch beats load-use; a flushed ID instruction never stalls
    if (run_rules) begin
      state_d = StRun;
      if (EX_Jump) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (BranchTaken) begin
        ifid_flush = 1'b1;
      end else if (lu) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
        if (STALL_CYCLES > 1) begin
          state_d  = StLuStall;
          lu_cnt_d = LuInit;
        end
      end
    end

    if (stall_rule) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_flush = 1'b1;
      lu_cnt_d   = lu_cnt_q - 3'd1;
      state_d    = (lu_cnt_q <= 3'd1) ? StRun : StLuStall;
    end
  end

  // Control outputs are forced quiet while reset is asserted
  assign PCHold      = Rst_n & pc_hold;
  assign IFIDHold    = Rst_n & ifid_hold;
  assign IFIDFlush   = Rst_n & ifid_flush;
  assign IDEXWrite   = Rst_n & idex_hold;
  assign FlushEnable = Rst_n & idex_flush;

  assign mem_err_d = mem_err_q |
                     ((state_q == StMemWait) && MemBusy && (wdog_q == WdogLimit));

  assign stall_cnt_d = (PCHold && (stall_cnt_q != CntMax)) ? stall_cnt_q + 16'd1 : stall_cnt_q;
  assign flush_cnt_d = ((IFIDFlush || FlushEnable) && (flush_cnt_q != CntMax)) ?
                       flush_cnt_q + 16'd1 : flush_cnt_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= StRun;
      lu_cnt_q    <= 3'd0;
      ret_lu_q    <= 1'b0;
      wdog_q      <= 16'd0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      state_q     <= state_d;
      lu_cnt_q    <= lu_cnt_d;
      ret_lu_q    <= ret_lu_d;
      wdog_q      <= wdog_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemErr   = mem_err_q;
  assign StallCnt = stall_cnt_q;
  assign FlushCnt = flush_cnt_q;

endmodule
